// File: rtl/ff256ct_wb_master_if.sv
// rtl/ff256ct_wb_master_if.sv - stream and Wishbone signal bundle for the FF256CT master
//
// Ports carried (names as seen from the master):
//   in_valid_i/in_ready_o/in_data_i     input vector stream (2*DATA_WIDTH wide)
//   out_valid_o/out_ready_i/out_data_o  result stream (2*DATA_WIDTH wide)
//   adr_o/data_o/data_i/we_o/sel_o/stb_o/cyc_o/ack_i  Wishbone classic bus
//   busy_o/err_o                        status (busy level, ack-timeout pulse)
interface ff256ct_wb_master_if #(
  parameter int BUS_WIDTH  = 1,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [2*DATA_WIDTH-1:0]   in_data_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [2*DATA_WIDTH-1:0]   out_data_o;
  logic [BUS_WIDTH-1:0]      adr_o;
  logic [DATA_WIDTH-1:0]     data_o;
  logic [DATA_WIDTH-1:0]     data_i;
  logic                      we_o;
  logic [BE_WIDTH-1:0]       sel_o;
  logic                      stb_o;
  logic                      cyc_o;
  logic                      ack_i;
  logic                      busy_o;
  logic                      err_o;

  modport master (
    input  in_valid_i, in_data_i, out_ready_i, data_i, ack_i,
    output in_ready_o, out_valid_o, out_data_o, adr_o, data_o, we_o,
           sel_o, stb_o, cyc_o, busy_o, err_o
  );

  modport slave (
    output in_valid_i, in_data_i, out_ready_i, data_i, ack_i,
    input  in_ready_o, out_valid_o, out_data_o, adr_o, data_o, we_o,
           sel_o, stb_o, cyc_o, busy_o, err_o
  );
endinterface

// File: rtl/ff256ct_wb_master.sv
// rtl/ff256ct_wb_master.sv - Wishbone classic master feeding the FF256 cosine-transform slave
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    ff256ct_wb_master_if.master: input vector stream, result stream,
//          Wishbone classic master signals, busy_o and err_o status
//
// One vector at a time: write low word (adr 0), write high word (adr 1), idle
// WAIT_CYCLES for the slave pipeline, read adr 0 and adr 1, present the result.
module ff256ct_wb_master #(
  parameter int BUS_WIDTH   = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int BE_WIDTH    = 4,
  parameter int WAIT_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  ff256ct_wb_master_if.master        bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR0  = 3'd1;
  localparam logic [2:0] WR1  = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RD0  = 3'd4;
  localparam logic [2:0] RD1  = 3'd5;
  localparam logic [2:0] OUT  = 3'd6;

  localparam int CNT_MAX = (TIMEOUT > WAIT_CYCLES) ? TIMEOUT : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  // With no settle time the second write goes straight into the first read.
  localparam logic [2:0] WR1_NEXT = (WAIT_CYCLES == 0) ? RD0 : WAIT;

  localparam int DW = DATA_WIDTH;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*DW-1:0]   vec_q, vec_d;
  logic [2*DW-1:0]   res_q, res_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              bus_state;
  logic              timeout;

  assign bus_state = (state_q == WR0) || (state_q == WR1) ||
                     (state_q == RD0) || (state_q == RD1);
  // cnt_q holds the number of completed cycles in the current state.
  assign timeout   = bus_state && !bus.ack_i && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    res_d   = res_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid_i && in_ready_q) begin
        vec_d   = bus.in_data_i;
        state_d = WR0;
      end
      WR0:  if (bus.ack_i) state_d = WR1;
      WR1:  if (bus.ack_i) state_d = WR1_NEXT;
      WAIT: if (cnt_q == WAIT_LAST) state_d = RD0;
      RD0:  if (bus.ack_i) begin
        res_d[DW-1:0] = bus.data_i;
        state_d       = RD1;
      end
      RD1:  if (bus.ack_i) begin
        res_d[2*DW-1:DW] = bus.data_i;
        state_d          = OUT;
      end
      OUT:  if (out_valid_q && bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    // Counter restarts on every state change and only runs where it is used.
    if ((state_d != state_q) || !(bus_state || (state_q == WAIT)))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    in_ready_d  = (state_d == IDLE);
    // Result valid follows OUT entry by one cycle and drops on the handshake.
    out_valid_d = (state_q == OUT) && !(out_valid_q && bus.out_ready_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Bus signals are a pure decode of the registered state.
  assign bus.cyc_o       = bus_state;
  assign bus.stb_o       = bus_state;
  assign bus.we_o        = (state_q == WR0) || (state_q == WR1);
  assign bus.adr_o       = BUS_WIDTH'((state_q == WR1) || (state_q == RD1));
  assign bus.sel_o       = bus_state ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
  assign bus.data_o      = (state_q == WR0) ? vec_q[DW-1:0] :
                           (state_q == WR1) ? vec_q[2*DW-1:DW] : '0;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = res_q;
  assign bus.err_o       = err_q;

endmodule
